// File: rtl/debounce_edge_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, tick-rate stability
// counter, debounced level register and single-cycle rise/fall pulses.
module debounce_edge_multi #(
  parameter int N_CH        = 4,
  parameter int STABLE_CNT  = 10,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            tick_in,
  input  logic [N_CH-1:0] D_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_event
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  samp;
  logic [N_CH-1:0][CNT_W-1:0]       cnt_q;
  logic [N_CH-1:0][CNT_W-1:0]       cnt_d;
  logic [N_CH-1:0]                  level_q;
  logic [N_CH-1:0]                  level_d;
  logic [N_CH-1:0]                  rise_q;
  logic [N_CH-1:0]                  rise_d;
  logic [N_CH-1:0]                  fall_q;
  logic [N_CH-1:0]                  fall_d;
  logic                             any_q;
  logic                             any_d;

  // Synchroniser shifts every clock; only the stability logic waits for a tick.
  assign samp = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D_in};
    end
  end

  // Any sample matching the current level clears the run, so bounce keeps no credit.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick_in) begin
      for (int i = 0; i < N_CH; i++) begin
        if (samp[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_TERM) begin
          level_d[i] = samp[i];
          cnt_d[i]   = '0;
          rise_d[i]  = samp[i];
          fall_d[i]  = ~samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    any_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_event  = any_q;

endmodule

// File: tb/tb_debounce_edge_multi.sv
// Bench for debounce_edge_multi: table-driven reset/latency vectors, directed
// corner sequences, and random stimulus against a sample-history reference model.
module tb_debounce_edge_multi;

  localparam int NC = 4;
  localparam int SC = 10;
  localparam int SS = 2;

  logic          clk_in;
  logic          reset;
  logic          tick_in;
  logic [NC-1:0] D_in;
  logic [NC-1:0] level_out;
  logic [NC-1:0] rise_pulse;
  logic [NC-1:0] fall_pulse;
  logic          any_event;

  logic          tick1;
  logic [0:0]    d1;
  logic [0:0]    level1;
  logic [0:0]    rise1;
  logic [0:0]    fall1;
  logic          any1;

  int n_checks = 0;
  int n_pass   = 0;

  debounce_edge_multi #(.N_CH(NC), .STABLE_CNT(SC), .CNT_W(4), .SYNC_STAGES(SS)) u_dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .D_in       (D_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_event  (any_event)
  );

  debounce_edge_multi #(.N_CH(1), .STABLE_CNT(1), .CNT_W(1), .SYNC_STAGES(3)) u_dut1 (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick1),
    .D_in       (d1),
    .level_out  (level1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .any_event  (any1)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Inputs change 2 time units after the rising edge; directed checks happen there too.
  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic do_reset(input logic [NC-1:0] d);
    reset   = 1'b1;
    D_in    = d;
    tick_in = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Synchronised sample = raw input seen SS edges ago; the level flips once the
  // last SC tick samples all disagree with it.
  logic [NC-1:0] m_hist [SS];
  bit            m_samp [NC][$];
  logic [NC-1:0] m_s;
  logic [NC-1:0] m_level;
  logic [NC-1:0] m_rise;
  logic [NC-1:0] m_fall;
  logic          m_any;

  function automatic bit all_differ(input int c);
    foreach (m_samp[c][k]) if (m_samp[c][k] == m_level[c]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      for (int c = 0; c < NC; c++) m_samp[c].delete();
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
    end else begin
      m_s = m_hist[SS-1];
      for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = D_in;
      m_rise = '0;
      m_fall = '0;
      if (tick_in) begin
        for (int c = 0; c < NC; c++) begin
          m_samp[c].push_back(m_s[c]);
          if (m_samp[c].size() > SC) void'(m_samp[c].pop_front());
          if (m_samp[c].size() == SC && all_differ(c)) begin
            m_level[c] = m_s[c];
            m_rise[c]  = m_s[c];
            m_fall[c]  = ~m_s[c];
            m_samp[c].delete();
          end
        end
      end
      m_any = |{m_rise, m_fall};
    end
  end

  // ---------------- scoreboard against the model ----------------
  always @(posedge clk_in) begin
    #1;
    check("mdl_level", 32'(level_out), 32'(m_level));
    check("mdl_rise",  32'(rise_pulse), 32'(m_rise));
    check("mdl_fall",  32'(fall_pulse), 32'(m_fall));
    check("mdl_any",   32'(any_event), 32'(m_any));
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [NC-1:0] d;
    logic          tick;
    logic [NC-1:0] lvl;
    logic [NC-1:0] rise;
    logic [NC-1:0] fall;
    logic          any;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int first_e;
    int cnt;
    int bad;
    logic [NC-1:0] rise_at;
    logic          any_at;
    bit bq[$];

    reset   = 1'b1;
    tick_in = 1'b1;
    D_in    = '0;
    tick1   = 1'b1;
    d1      = 1'b0;

    // Reset with all inputs high: level rises after edge 11, pulse gone after edge 12.
    for (int k = 0; k < 13; k++) begin
      tbl[k].d    = 4'hf;
      tbl[k].tick = 1'b1;
      tbl[k].lvl  = (k >= 11) ? 4'hf : 4'h0;
      tbl[k].rise = (k == 11) ? 4'hf : 4'h0;
      tbl[k].fall = 4'h0;
      tbl[k].any  = (k == 11);
    end
    do_reset(4'hf);
    for (int k = 0; k < 13; k++) begin
      D_in    = tbl[k].d;
      tick_in = tbl[k].tick;
      step();
      check($sformatf("tbl_level[%0d]", k), 32'(level_out), 32'(tbl[k].lvl));
      check($sformatf("tbl_rise[%0d]", k),  32'(rise_pulse), 32'(tbl[k].rise));
      check($sformatf("tbl_fall[%0d]", k),  32'(fall_pulse), 32'(tbl[k].fall));
      check($sformatf("tbl_any[%0d]", k),   32'(any_event), 32'(tbl[k].any));
    end

    // Ch0 bounce: only the final held run of 1s may produce a pulse.
    do_reset(4'h0);
    repeat (3) step();
    bq = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
    cnt = 0;
    bad = 0;
    foreach (bq[k]) begin
      D_in[0] = bq[k];
      step();
      if (rise_pulse[0]) cnt++;
      if (rise_pulse[3:1] != 3'b0 || fall_pulse != 4'b0) bad++;
    end
    D_in[0] = 1'b1;
    first_e = -1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (rise_pulse[0]) begin
        cnt++;
        if (first_e < 0) first_e = e;
      end
      if (rise_pulse[3:1] != 3'b0 || fall_pulse != 4'b0) bad++;
    end
    check("bounce_rise_count", 32'(cnt), 32'd1);
    check("bounce_rise_edge", 32'(first_e), 32'd11);
    check("bounce_others_quiet", 32'(bad), 32'd0);
    check("bounce_level", 32'(level_out), 32'h1);

    // Ch2 falling edge after being debounced high.
    D_in[2] = 1'b1;
    repeat (14) step();
    check("fall_pre_level", 32'(level_out), 32'h5);
    D_in[2] = 1'b0;
    first_e = -1;
    cnt = 0;
    bad = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (fall_pulse[2]) begin
        cnt++;
        if (first_e < 0) first_e = e;
      end
      if (rise_pulse != 4'b0) bad++;
    end
    check("fall_count", 32'(cnt), 32'd1);
    check("fall_edge", 32'(first_e), 32'd11);
    check("fall_level", 32'(level_out), 32'h1);
    check("fall_no_rise", 32'(bad), 32'd0);

    // Slow tick every 8th cycle: ch1 flips on the 10th tick (edge 80), pulse one cycle wide.
    do_reset(4'h0);
    D_in = 4'b0010;
    first_e = -1;
    cnt = 0;
    bad = -1;
    for (int e = 0; e < 90; e++) begin
      tick_in = (e > 0 && e % 8 == 0);
      step();
      if (level_out[1] && first_e < 0) first_e = e;
      if (rise_pulse[1]) begin
        cnt++;
        if (bad < 0) bad = e;
      end
    end
    tick_in = 1'b1;
    check("slow_level_edge", 32'(first_e), 32'd80);
    check("slow_rise_edge", 32'(bad), 32'd80);
    check("slow_rise_width", 32'(cnt), 32'd1);

    // Reset mid-count on ch3 (count 7) while ch0 is already high.
    do_reset(4'h0);
    D_in = 4'b0001;
    repeat (14) step();
    check("mid_pre_level", 32'(level_out), 32'h1);
    D_in = 4'b1001;
    repeat (9) step();
    reset = 1'b1;
    #1;
    check("mid_rst_level", 32'(level_out), 32'h0);
    check("mid_rst_pulses", 32'({rise_pulse, fall_pulse, any_event}), 32'h0);
    step();
    step();
    reset = 1'b0;
    first_e = -1;
    rise_at = '0;
    any_at  = 1'b0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (rise_pulse[3] && first_e < 0) begin
        first_e = e;
        rise_at = rise_pulse;
        any_at  = any_event;
      end
    end
    check("mid_rise_edge", 32'(first_e), 32'd11);
    check("mid_rise_both", 32'(rise_at), 32'h9);
    check("mid_any_single", 32'(any_at), 32'd1);

    // STABLE_CNT=1, SYNC_STAGES=3 instance: change visible after edge 3.
    for (int t = 0; t < 4; t++) begin
      d1 = ~d1;
      first_e = -1;
      cnt = 0;
      bad = 0;
      for (int e = 0; e < 6; e++) begin
        step();
        if (level1 == d1 && first_e < 0) first_e = e;
        if ((d1[0] && rise1[0]) || (!d1[0] && fall1[0])) cnt++;
        if ((d1[0] && fall1[0]) || (!d1[0] && rise1[0])) bad++;
      end
      check($sformatf("sweep_edge[%0d]", t), 32'(first_e), 32'd3);
      check($sformatf("sweep_pulse[%0d]", t), 32'(cnt), 32'd1);
      check($sformatf("sweep_wrong[%0d]", t), 32'(bad), 32'd0);
    end

    // Random stimulus: fast bouncy inputs with random ticks and rare resets.
    do_reset(4'h0);
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 11) == 0) D_in[c] = ~D_in[c];
      tick_in = ($urandom_range(0, 2) != 0);
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    // Slower input changes with tick high so levels settle and flip often.
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 24) == 0) D_in[c] = ~D_in[c];
      tick_in = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
